// File: rtl/soc_interface_wb_slave_32.sv
// Wishbone classic slave that forwards each bus cycle as a byte-wide command packet
// and terminates it from the matching response packet.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for wb_cyc_i & wb_stb_i
// SEND      | streaming command bytes on output_axis
// WAIT_RESP | waiting for the response status byte
// RECV      | collecting the 4 read-data bytes
// DRAIN     | discarding an over-long response up to its tlast
// ACK       | one-cycle wb_ack_o
// ERR       | one-cycle wb_err_o
module soc_interface_wb_slave_32 #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [7:0]  output_axis_tdata,
  output logic        output_axis_tvalid,
  output logic        output_axis_tlast,
  input  logic        output_axis_tready,
  input  logic [7:0]  input_axis_tdata,
  input  logic        input_axis_tvalid,
  input  logic        input_axis_tlast,
  output logic        input_axis_tready,
  output logic        busy
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_RESP, S_RECV, S_DRAIN, S_ACK, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [35:0]   adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic [3:0]    tx_idx;
  logic [1:0]    rx_cnt;
  logic [23:0]   rx_shift;
  logic          status_bad;
  logic          aborted;
  logic [TW-1:0] tmr_q;

  logic          start, tx_fire, rx_fire, tx_last, tmr_expired;
  logic [7:0]    tx_byte;
  logic [3:0]    tx_last_idx;

  assign start       = wb_cyc_i && wb_stb_i;
  assign tx_last_idx = we_q ? 4'd10 : 4'd6;
  assign tx_last     = (tx_idx == tx_last_idx);
  assign tx_fire     = (state_q == S_SEND) && output_axis_tready;
  assign rx_fire     = input_axis_tready && input_axis_tvalid;
  // Terminal count: the timer is reloaded with TIMEOUT-1 so that reaching zero
  // marks the TIMEOUT-th cycle spent waiting.
  assign tmr_expired = (TIMEOUT != 0) && (tmr_q == '0);

  always_comb begin
    tx_byte = 8'h00;
    case (tx_idx)
      4'd0:    tx_byte = we_q ? 8'hB2 : 8'hB1;
      4'd1:    tx_byte = {4'h0, adr_q[35:32]};
      4'd2:    tx_byte = adr_q[31:24];
      4'd3:    tx_byte = adr_q[23:16];
      4'd4:    tx_byte = adr_q[15:8];
      4'd5:    tx_byte = adr_q[7:0];
      4'd6:    tx_byte = {4'h0, sel_q};
      4'd7:    tx_byte = dat_q[31:24];
      4'd8:    tx_byte = dat_q[23:16];
      4'd9:    tx_byte = dat_q[15:8];
      4'd10:   tx_byte = dat_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    output_axis_tvalid = 1'b0;
    output_axis_tdata  = 8'h00;
    output_axis_tlast  = 1'b0;
    input_axis_tready  = 1'b0;
    wb_ack_o           = 1'b0;
    wb_err_o           = 1'b0;
    busy               = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: if (start) state_d = S_SEND;
      S_SEND: begin
        output_axis_tvalid = 1'b1;
        output_axis_tdata  = tx_byte;
        output_axis_tlast  = tx_last;
        if (tx_fire && tx_last) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        input_axis_tready = 1'b1;
        if (rx_fire) begin
          if (we_q)
            state_d = !input_axis_tlast ? S_DRAIN :
                      (input_axis_tdata == 8'h00) ? S_ACK : S_ERR;
          else
            state_d = input_axis_tlast ? S_ERR : S_RECV;
        end else if (tmr_expired) begin
          state_d = S_ERR;
        end
      end
      S_RECV: begin
        input_axis_tready = 1'b1;
        if (rx_fire) begin
          if (rx_cnt == 2'd3)
            state_d = !input_axis_tlast ? S_DRAIN : status_bad ? S_ERR : S_ACK;
          else if (input_axis_tlast)
            state_d = S_ERR;
        end else if (tmr_expired) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        input_axis_tready = 1'b1;
        if (rx_fire && input_axis_tlast) state_d = S_ERR;
      end
      // Terminations are swallowed once the master has abandoned the cycle.
      S_ACK: begin
        wb_ack_o = wb_cyc_i && !aborted;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        wb_err_o = wb_cyc_i && !aborted;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      tx_idx     <= '0;
      rx_cnt     <= '0;
      rx_shift   <= '0;
      status_bad <= 1'b0;
      aborted    <= 1'b0;
      tmr_q      <= '0;
      wb_dat_o   <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        adr_q   <= wb_adr_i;
        dat_q   <= wb_dat_i;
        sel_q   <= wb_sel_i;
        we_q    <= wb_we_i;
        tx_idx  <= '0;
        aborted <= 1'b0;
      end else if (state_q != S_IDLE && !wb_cyc_i) begin
        aborted <= 1'b1;
      end

      if (tx_fire) tx_idx <= tx_idx + 4'd1;

      if ((state_q == S_SEND && state_d == S_WAIT_RESP) || rx_fire)
        tmr_q <= TMR_LOAD;
      else if ((state_q == S_WAIT_RESP || state_q == S_RECV) && tmr_q != '0)
        tmr_q <= tmr_q - 1'b1;

      if (rx_fire && state_q == S_WAIT_RESP) begin
        status_bad <= (input_axis_tdata != 8'h00);
        rx_cnt     <= '0;
      end else if (rx_fire && state_q == S_RECV) begin
        rx_shift <= {rx_shift[15:0], input_axis_tdata};
        rx_cnt   <= rx_cnt + 2'd1;
        if (rx_cnt == 2'd3) wb_dat_o <= {rx_shift, input_axis_tdata};
      end
    end
  end

endmodule

// File: tb/tb_soc_interface_wb_slave_32.sv
// Bench for soc_interface_wb_slave_32: directed and random bus cycles checked
// against a packet-level model of the command/response protocol.
module tb_soc_interface_wb_slave_32;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] wb_adr_i;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_we_i, wb_stb_i, wb_cyc_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o, wb_err_o;
  logic [7:0]  output_axis_tdata;
  logic        output_axis_tvalid, output_axis_tlast, output_axis_tready;
  logic [7:0]  input_axis_tdata;
  logic        input_axis_tvalid, input_axis_tlast, input_axis_tready;
  logic        busy;

  always #5 clk = ~clk;

  soc_interface_wb_slave_32 #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .output_axis_tdata(output_axis_tdata), .output_axis_tvalid(output_axis_tvalid),
    .output_axis_tlast(output_axis_tlast), .output_axis_tready(output_axis_tready),
    .input_axis_tdata(input_axis_tdata), .input_axis_tvalid(input_axis_tvalid),
    .input_axis_tlast(input_axis_tlast), .input_axis_tready(input_axis_tready),
    .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] rsp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/tvalid"}, output_axis_tvalid, 0);
    chk({tag, "/tlast"}, output_axis_tlast, 0);
    chk({tag, "/tdata"}, output_axis_tdata, 0);
    chk({tag, "/in_tready"}, input_axis_tready, 0);
    chk({tag, "/ack"}, wb_ack_o, 0);
    chk({tag, "/err"}, wb_err_o, 0);
    chk({tag, "/busy"}, busy, 0);
    chk({tag, "/dat_o"}, wb_dat_o, 0);
  endtask

  // Expected command bytes straight from the packet layout.
  task automatic build_cmd(input logic we, input logic [35:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    exp_q.delete();
    exp_q.push_back(we ? 8'hB2 : 8'hB1);
    for (int i = 4; i >= 0; i--) exp_q.push_back(8'((adr >> (8 * i)) & 36'hFF));
    exp_q.push_back({4'h0, sel});
    if (we) for (int i = 3; i >= 0; i--) exp_q.push_back(8'(dat >> (8 * i)));
  endtask

  // One complete bus cycle; the response packet comes from rsp_q with tlast on its
  // final byte (an empty rsp_q means no response at all).
  task automatic run_txn(input logic we, input logic [35:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int bp_pct, input bit drop_cyc,
                         input string tag);
    int          cyc_cnt, last_pos, n_ack, n_err, n_both, want_len, guard, wait_n;
    logic        prev_stall, prev_last, exp_ack, seen, seen_prev;
    logic [7:0]  prev_data;
    logic [31:0] exp_dat, dat_at_ack;

    build_cmd(we, adr, dat, sel);
    want_len = we ? 1 : 5;
    exp_ack  = (rsp_q.size() == want_len) && (rsp_q[0] == 8'h00);
    exp_dat  = (rsp_q.size() >= 5) ? {rsp_q[1], rsp_q[2], rsp_q[3], rsp_q[4]} : 32'h0;

    wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    got_q.delete();
    last_pos = -1; prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
    @(posedge clk); #1;
    cyc_cnt = 0;
    while (cyc_cnt < 400) begin
      output_axis_tready = ($urandom_range(0, 99) >= bp_pct);
      if (prev_stall) begin
        chk({tag, "/stall_valid"}, output_axis_tvalid, 1);
        chk({tag, "/stall_data"}, output_axis_tdata, prev_data);
        chk({tag, "/stall_last"}, output_axis_tlast, prev_last);
      end
      chk({tag, "/send_busy"}, busy, 1);
      chk({tag, "/send_no_rx_ready"}, input_axis_tready, 0);
      prev_stall = output_axis_tvalid && !output_axis_tready;
      prev_data  = output_axis_tdata;
      prev_last  = output_axis_tlast;
      if (drop_cyc && got_q.size() == 3) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
      if (output_axis_tvalid && output_axis_tready) begin
        if (output_axis_tlast) last_pos = got_q.size();
        got_q.push_back(output_axis_tdata);
      end
      @(posedge clk); #1;
      cyc_cnt++;
      if (last_pos >= 0) break;
    end
    output_axis_tready = 1'b0;
    chk({tag, "/cmd_len"}, got_q.size(), exp_q.size());
    chk({tag, "/tlast_pos"}, last_pos, exp_q.size() - 1);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s/cmd_byte%0d", tag, i), got_q[i], exp_q[i]);

    if (rsp_q.size() == 0) begin
      wait_n = 0;
      while (!wb_err_o && !wb_ack_o && wait_n < 100) begin @(posedge clk); #1; wait_n++; end
      chk({tag, "/timeout_latency"}, wait_n, TMO);
    end else begin
      foreach (rsp_q[i]) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        input_axis_tvalid = 1'b1;
        input_axis_tdata  = rsp_q[i];
        input_axis_tlast  = (i == rsp_q.size() - 1);
        guard = 0;
        while (!input_axis_tready && guard < 20) begin @(posedge clk); #1; guard++; end
        chk($sformatf("%s/rsp_accept%0d", tag, i), guard < 20, 1);
        @(posedge clk); #1;
        input_axis_tvalid = 1'b0;
        input_axis_tlast  = 1'b0;
        input_axis_tdata  = 8'h00;
      end
    end

    n_ack = 0; n_err = 0; n_both = 0; seen = 1'b0; seen_prev = 1'b0; dat_at_ack = 32'h0;
    for (int k = 0; k < 30; k++) begin
      if (seen_prev) begin
        chk({tag, "/busy_after_term"}, busy, 0);
        seen_prev = 1'b0;
      end
      if (wb_ack_o && wb_err_o) n_both++;
      if (wb_ack_o) begin n_ack++; dat_at_ack = wb_dat_o; end
      if (wb_err_o) n_err++;
      if ((wb_ack_o || wb_err_o) && !seen) begin
        seen = 1'b1; seen_prev = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk({tag, "/ack_count"}, n_ack, (!drop_cyc && exp_ack) ? 1 : 0);
    chk({tag, "/err_count"}, n_err, (!drop_cyc && !exp_ack) ? 1 : 0);
    chk({tag, "/ack_and_err"}, n_both, 0);
    if (!we && exp_ack && !drop_cyc) chk({tag, "/rd_data"}, dat_at_ack, exp_dat);
    chk({tag, "/idle_at_end"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, kind, want;
    logic        we;
    logic [7:0]  st;
    logic [35:0] adr;

    rst = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    wb_sel_i = '0; output_axis_tready = 1'b0;
    input_axis_tdata = '0; input_axis_tvalid = 1'b0; input_axis_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    rsp_q = {8'h00};
    run_txn(1'b1, 36'h0_1234_5678, 32'hDEADBEEF, 4'hF, 0, 1'b0, "wr_basic");
    rsp_q = {8'h00, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    run_txn(1'b0, 36'hF_0000_0004, 32'h0, 4'h3, 0, 1'b0, "rd_basic");
    rsp_q = {8'h00};
    run_txn(1'b1, 36'h0_1234_5678, 32'hDEADBEEF, 4'hF, 50, 1'b0, "wr_backpressure");
    rsp_q = {8'h00, 8'h11, 8'h22};
    run_txn(1'b0, 36'h3_00AA_0010, 32'h0, 4'hF, 0, 1'b0, "rd_short");
    rsp_q = {8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_txn(1'b0, 36'h3_00AA_0014, 32'h0, 4'hF, 0, 1'b0, "rd_long");
    rsp_q.delete();
    run_txn(1'b1, 36'h0_0000_0100, 32'h12345678, 4'h1, 0, 1'b0, "wr_timeout");
    rsp_q = {8'h01};
    run_txn(1'b1, 36'h0_0000_0104, 32'h87654321, 4'hC, 0, 1'b0, "wr_status_err");
    rsp_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    run_txn(1'b0, 36'h1_0000_0000, 32'h0, 4'hF, 30, 1'b1, "rd_cyc_dropped");
    rsp_q = {8'h00, 8'h5A, 8'hA5, 8'h0F, 8'hF0};
    run_txn(1'b0, 36'h2_0000_0008, 32'h0, 4'h8, 20, 1'b0, "rd_after_drop");

    for (int t = 0; t < 20; t++) begin
      we   = 1'($urandom_range(0, 1));
      adr  = {4'($urandom()), $urandom()};
      want = we ? 1 : 5;
      kind = $urandom_range(0, 9);
      if (kind == 0 && !we) n = $urandom_range(1, 4);
      else if (kind == 1)   n = want + $urandom_range(1, 2);
      else                  n = want;
      st = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      rsp_q.delete();
      for (int i = 0; i < n; i++) rsp_q.push_back(i == 0 ? st : 8'($urandom()));
      run_txn(we, adr, $urandom(), 4'($urandom()), $urandom_range(0, 60), 1'b0,
              $sformatf("rand%0d", t));
    end

    // Reset while the 5th command byte is on the stream.
    adr = 36'h0_1234_5678;
    wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = 32'hDEADBEEF; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; output_axis_tready = 1'b1;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_mid/fifth_byte", output_axis_tdata, 8'(adr >> 8));
    rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("rst_mid");
    rst = 1'b1; output_axis_tready = 1'b0;
    rsp_q = {8'h00};
    run_txn(1'b1, 36'h0_1234_5678, 32'hDEADBEEF, 4'hF, 0, 1'b0, "wr_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/soc_interface_wb_slave_32.md
SOC_INTERFACE_WB_SLAVE_32 -- requirements
Module: soc_interface_wb_slave_32

Interface
REQ-001 Parameter TIMEOUT, default 1024: cycles in WAIT_RESP/RECV before the cycle is failed with error; 0 disables the timeout.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-004 wb_adr_i  input  36  Wishbone slave address.
REQ-005 wb_dat_i  input  32  write data.
REQ-006 wb_dat_o  output  32  read data, valid with wb_ack_o.
REQ-007 wb_we_i, wb_stb_i, wb_cyc_i  input  1 each  Wishbone classic controls.
REQ-008 wb_sel_i  input  4  byte selects.
REQ-009 wb_ack_o, wb_err_o  output  1 each  single-cycle termination pulses.
REQ-010 output_axis_tdata/tvalid/tlast  output  8/1/1  command packet stream; output_axis_tready  input  1.
REQ-011 input_axis_tdata/tvalid/tlast  input  8/1/1  response packet stream; input_axis_tready  output  1.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 Cycle start: in IDLE with wb_cyc_i&wb_stb_i high, latch adr, dat, sel, we; go to SEND.
REQ-014 Command packet, one byte per accepted beat (tvalid&tready), MSB-first: cmd (0xB2 write, 0xB1 read), adr as 5 bytes ({4'b0,adr[35:32]} first), sel byte ({4'b0,sel}), then for writes 4 data bytes; tlast on final byte (7 bytes read, 11 bytes write).
REQ-015 output_axis_tdata/tlast stable while tvalid high and tready low; tvalid never drops before the beat is accepted.
REQ-016 After last command beat, go to WAIT_RESP; input_axis_tready high only in WAIT_RESP, RECV, DRAIN.
REQ-017 Response: status byte (0x00 = OK, nonzero = error); for reads followed by 4 data bytes MSB-first; tlast on final byte.
REQ-018 Write: status byte with tlast -> ACK state if 0x00, else ERR state.
REQ-019 Read: status byte without tlast -> RECV, shifting 4 bytes into wb_dat_o; tlast exactly on 4th data byte -> ACK (status OK) or ERR (status nonzero).
REQ-020 Framing error: tlast earlier than expected -> ERR immediately; expected-last byte without tlast -> DRAIN, discard until tlast, then ERR.
REQ-021 ACK/ERR states: assert wb_ack_o or wb_err_o for exactly one cycle, then IDLE; never both.
REQ-022 Timeout: counter clears on entry to WAIT_RESP and on each accepted response beat; reaching TIMEOUT -> DRAIN if mid-packet else ERR (WAIT_RESP) ; counter width ceil(log2(TIMEOUT+1)).
REQ-023 wb_cyc_i dropped before termination: cycle completes internally (packet sent, response consumed); ack/err suppressed.
REQ-024 Input beats arriving in IDLE/SEND are not accepted (tready low); no response buffering.
REQ-025 wb_dat_o holds last read value until next read response; zero on write cycles is not required.
REQ-026 Minimum latency, write, tready and response always ready: stb to ack = 11 send cycles + 1 wait + 1 ack = 13 cycles.

Reset
REQ-027 rst low at a rising edge: state IDLE, all outputs 0 (tvalid, tlast, tdata, tready, ack, err, busy, wb_dat_o), counters cleared, regardless of current state.
REQ-028 Reset mid-packet abandons it; no ack/err issued; next cycle after rst high may accept a new stb.

Verification
REQ-029 Write adr 0x0_1234_5678, dat 0xDEADBEEF, sel 0xF, tready=1; response 0x00+tlast -> bytes B2 00 12 34 56 78 0F DE AD BE EF (tlast on EF), one ack pulse, busy low next cycle.
REQ-030 Read adr 0xF_0000_0004, sel 0x3; response 00 CA FE BA BE (tlast on BE) -> bytes B1 0F 00 00 00 04 03, ack with wb_dat_o=0xCAFEBABE.
REQ-031 Random output_axis_tready backpressure (50%) on write -> identical byte sequence, data stable while stalled, single ack.
REQ-032 Read response 00 11 22 (tlast on 22) -> err pulse, no ack; read response 00 11 22 33 44 55 without tlast until 55 -> DRAIN consumes 55, then err.
REQ-033 TIMEOUT=16, no response -> err exactly 16 cycles after WAIT_RESP entry; write status 0x01 -> err.
REQ-034 rst low during 5th command byte -> all outputs 0 next cycle; subsequent write completes normally with ack.
